vga_sincronizador: RTL and testbench
====================================

Name: vga_sincronizador

Overview:
Timing generator for the VGA path. It produces the pixel-coordinate counters Qh/Qv that the character renderers consume, plus HSYNC/VSYNC, the visible-area flag and line/frame markers. It sits between the board clock and all Qh/Qv-driven display logic. The default timing is 640x480@60 Hz from a 100 MHz clock.

Parameters:
HD, 640, visible pixels per line
HF, 16, horizontal front porch (pixel ticks)
HR, 96, horizontal sync pulse width
HB, 48, horizontal back porch
VD, 480, visible lines per frame
VF, 10, vertical front porch (lines)
VR, 2, vertical sync pulse width
VB, 33, vertical back porch
DIV, 4, reloj cycles per pixel tick (>=2)

Ports:
reloj  input  1  system clock, rising edge
resetM  input  1  asynchronous, active-low reset
Qh  output  10  horizontal pixel counter, 0..HMAX-1 (HMAX=HD+HF+HR+HB=800)
Qv  output  10  vertical line counter, 0..VMAX-1 (VMAX=VD+VF+VR+VB=525)
hsync  output  1  horizontal sync, active-low
vsync  output  1  vertical sync, active-low
video_on  output  1  high while (Qh,Qv) is inside the visible area
p_tick  output  1  one-reloj pulse per pixel period
fin_linea  output  1  one-reloj pulse on the tick where Qh wraps
fin_cuadro  output  1  one-reloj pulse on the tick where both Qh and Qv wrap

Behaviour:
- All outputs are registered. The only asynchronous path is resetM low.
- Reset (resetM=0, immediate): prescaler=0, Qh=0, Qv=0, hsync=1, vsync=1, video_on=0, p_tick=0, fin_linea=0, fin_cuadro=0.
- Prescaler counts 0..DIV-1 and wraps. p_tick=1 for exactly the one cycle in which the prescaler equals DIV-1. First p_tick occurs DIV cycles after reset release.
- Qh/Qv update only on the reloj edge that ends a p_tick cycle, and hold otherwise.
  - Qh==HMAX-1: Qh->0.
  - Otherwise: Qh->Qh+1.
  - On the Qh wrap, Qv increments; if Qv==VMAX-1 it wraps to 0.
- fin_linea=1 during the p_tick cycle with Qh==HMAX-1. fin_cuadro=1 during the p_tick cycle with Qh==HMAX-1 and Qv==VMAX-1. Both are 0 at all other times.
- hsync, vsync and video_on are decoded from the next counter values and registered on the same edge as Qh/Qv, so they are cycle-aligned with the Qh/Qv on the outputs (zero relative latency).
  - hsync=0 iff HD+HF <= Qh <= HD+HF+HR-1 (656..751).
  - vsync=0 iff VD+VF <= Qv <= VD+VF+VR-1 (490..491).
  - video_on=1 iff Qh<HD and Qv<VD. It stays 0 after reset until the first counter update, so (0,0) is first shown as visible at the start of the second pixel (1,0).
- Width rules: counters are 10-bit unsigned and all comparisons are unsigned. HMAX and VMAX must each be <=1024; this is checked at elaboration.
- resetM asserted mid-frame aborts the frame immediately to reset values. The timing restarts from (0,0) with a full DIV-cycle prescale.
- Simultaneous line and frame wrap are handled in the same edge. No glitch cycle is allowed in which Qv=VMAX while Qh=0.

Decomposition:
- Shared package vga_timing_pkg holds: the timing constants (HD..VB, HMAX, VMAX), derived sync start/end values, and the counter width constant CW=10. The renderers use the same package for the visible-area limits.
- One natural sub-module, vga_divisor_pixel: prescaler that generates p_tick with parameter DIV and asynchronous active-low reset.
- Counters and decode stay in the top module.

Test Plan:
- Reset: hold resetM=0 for 10 cycles -> Qh=0, Qv=0, hsync=1, vsync=1, video_on=0, p_tick=0. Release -> first p_tick at cycle 4, then every 4 cycles exactly.
- Line timing: run one line -> hsync falls in the same cycle Qh becomes 656 and rises when Qh becomes 752 (96 ticks low); video_on falls when Qh goes 639->640.
- Line wrap: at Qh=799, Qv=10, a tick -> Qh=0, Qv=11, fin_linea pulses for exactly 1 cycle, fin_cuadro stays 0.
- Frame wrap: run to Qh=799, Qv=524, a tick -> Qh=0, Qv=0, fin_linea and fin_cuadro both pulse. Over a full frame: vsync is low exactly 2 lines (Qv 490, 491); total 420000 ticks = 1680000 reloj cycles per frame.
- Asynchronous reset mid-frame: assert resetM=0 between clock edges at Qh=300, Qv=200 -> outputs reach reset values without waiting for an edge. After release, timing restarts from (0,0) with a 4-cycle first tick.
- Parameter override: DIV=2, HD=8, HF=2, HR=2, HB=2, VD=4, VF=1, VR=1, VB=1 -> HMAX=14 and VMAX=7 wraps observed; hsync low for Qh 10..11; vsync low for Qv 5.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 Hz from 100 MHz) used by the sync generator
// and by the Qh/Qv-driven renderers.
package vga_timing_pkg;

  localparam int unsigned CW = 10;

  localparam int unsigned HD = 640;
  localparam int unsigned HF = 16;
  localparam int unsigned HR = 96;
  localparam int unsigned HB = 48;
  localparam int unsigned VD = 480;
  localparam int unsigned VF = 10;
  localparam int unsigned VR = 2;
  localparam int unsigned VB = 33;
  localparam int unsigned DIV = 4;

  localparam int unsigned HMAX = HD + HF + HR + HB;
  localparam int unsigned VMAX = VD + VF + VR + VB;

  localparam int unsigned HSyncIni = HD + HF;
  localparam int unsigned HSyncFin = HD + HF + HR - 1;
  localparam int unsigned VSyncIni = VD + VF;
  localparam int unsigned VSyncFin = VD + VF + VR - 1;

  // Inclusive unsigned window test on a counter value.
  function automatic logic en_rango(input logic [CW-1:0] v, input logic [CW-1:0] lo,
                                    input logic [CW-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sincronizador_if.sv
// Timing bus from the sync generator (master) to the Qh/Qv-driven display logic (slave).
interface vga_sincronizador_if;
  import vga_timing_pkg::*;

  logic [CW-1:0] Qh;
  logic [CW-1:0] Qv;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          p_tick;
  logic          fin_linea;
  logic          fin_cuadro;

  modport master (
    output Qh, Qv, hsync, vsync, video_on, p_tick, fin_linea, fin_cuadro
  );

  modport slave (
    input Qh, Qv, hsync, vsync, video_on, p_tick, fin_linea, fin_cuadro
  );

endinterface

// File: rtl/vga_divisor_pixel.sv
// Pixel prescaler: counts 0..DIV-1 and raises a registered one-cycle p_tick at DIV-1.
module vga_divisor_pixel #(
  parameter int unsigned DIV = 4
) (
  input  logic reloj_i,
  input  logic rst_ni,
  output logic p_tick_o,
  output logic p_tick_next_o
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] Last = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          p_tick_q, p_tick_d;

  always_comb begin
    cnt_d    = (cnt_q == Last) ? '0 : cnt_q + PW'(1);
    p_tick_d = (cnt_d == Last);
  end

  always_ff @(posedge reloj_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      p_tick_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      p_tick_q <= p_tick_d;
    end
  end

  assign p_tick_o      = p_tick_q;
  // Lets the top register markers that must coincide with the upcoming p_tick cycle.
  assign p_tick_next_o = p_tick_d;

endmodule

// File: rtl/vga_sincronizador.sv
// VGA timing generator: Qh/Qv pixel counters plus registered sync, visible-area and
// line/frame markers, all cycle-aligned with the counters.
module vga_sincronizador #(
  parameter int unsigned DIV = vga_timing_pkg::DIV,
  parameter int unsigned HD  = vga_timing_pkg::HD,
  parameter int unsigned HF  = vga_timing_pkg::HF,
  parameter int unsigned HR  = vga_timing_pkg::HR,
  parameter int unsigned HB  = vga_timing_pkg::HB,
  parameter int unsigned VD  = vga_timing_pkg::VD,
  parameter int unsigned VF  = vga_timing_pkg::VF,
  parameter int unsigned VR  = vga_timing_pkg::VR,
  parameter int unsigned VB  = vga_timing_pkg::VB
) (
  input logic                 reloj,
  input logic                 resetM,
  vga_sincronizador_if.master bus
);
  import vga_timing_pkg::*;

  localparam int unsigned HMAX = HD + HF + HR + HB;
  localparam int unsigned VMAX = VD + VF + VR + VB;

  if (HMAX > (1 << CW) || VMAX > (1 << CW) || DIV < 2) begin : g_param_check
    $error("vga_sincronizador: HMAX and VMAX must be <= 1024 and DIV >= 2");
  end

  localparam logic [CW-1:0] HLast    = CW'(HMAX - 1);
  localparam logic [CW-1:0] VLast    = CW'(VMAX - 1);
  localparam logic [CW-1:0] HVis     = CW'(HD);
  localparam logic [CW-1:0] VVis     = CW'(VD);
  localparam logic [CW-1:0] HSyncLo  = CW'(HD + HF);
  localparam logic [CW-1:0] HSyncHi  = CW'(HD + HF + HR - 1);
  localparam logic [CW-1:0] VSyncLo  = CW'(VD + VF);
  localparam logic [CW-1:0] VSyncHi  = CW'(VD + VF + VR - 1);

  logic          tick, tick_next;
  logic [CW-1:0] qh_q, qh_d, qv_q, qv_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic          fin_linea_q, fin_linea_d, fin_cuadro_q, fin_cuadro_d;

  vga_divisor_pixel #(
    .DIV(DIV)
  ) u_divisor (
    .reloj_i      (reloj),
    .rst_ni       (resetM),
    .p_tick_o     (tick),
    .p_tick_next_o(tick_next)
  );

  always_comb begin
    qh_d       = qh_q;
    qv_d       = qv_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
    if (tick) begin
      if (qh_q == HLast) begin
        qh_d = '0;
        qv_d = (qv_q == VLast) ? '0 : qv_q + CW'(1);
      end else begin
        qh_d = qh_q + CW'(1);
      end
      // Decode the next counters so the flags land on the same edge as Qh/Qv.
      hsync_d    = ~en_rango(qh_d, HSyncLo, HSyncHi);
      vsync_d    = ~en_rango(qv_d, VSyncLo, VSyncHi);
      video_on_d = (qh_d < HVis) && (qv_d < VVis);
    end
    // DIV >= 2 keeps the counters stable on the edge that opens a p_tick cycle.
    fin_linea_d  = tick_next && (qh_q == HLast);
    fin_cuadro_d = fin_linea_d && (qv_q == VLast);
  end

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      qh_q         <= '0;
      qv_q         <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b0;
      fin_linea_q  <= 1'b0;
      fin_cuadro_q <= 1'b0;
    end else begin
      qh_q         <= qh_d;
      qv_q         <= qv_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      fin_linea_q  <= fin_linea_d;
      fin_cuadro_q <= fin_cuadro_d;
    end
  end

  assign bus.Qh         = qh_q;
  assign bus.Qv         = qv_q;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.video_on   = video_on_q;
  assign bus.p_tick     = tick;
  assign bus.fin_linea  = fin_linea_q;
  assign bus.fin_cuadro = fin_cuadro_q;

endmodule

// File: tb/tb_vga_sincronizador.sv
// Directed bench: default 640x480 timing (dut_a) and a shrunken override (dut_b, 14x7, DIV=2).
module tb_vga_sincronizador;

  logic clk     = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vga_sincronizador_if bus_a ();
  vga_sincronizador_if bus_b ();

  vga_sincronizador u_dut_a (
    .reloj (clk),
    .resetM(rst_a_n),
    .bus   (bus_a)
  );

  vga_sincronizador #(
    .DIV(2), .HD(8), .HF(2), .HR(2), .HB(2), .VD(4), .VF(1), .VR(1), .VB(1)
  ) u_dut_b (
    .reloj (clk),
    .resetM(rst_b_n),
    .bus   (bus_b)
  );

  // flg = {hsync, vsync, video_on, p_tick, fin_linea, fin_cuadro}
  typedef struct {
    int unsigned edges;
    int unsigned qh;
    int unsigned qv;
    logic [5:0]  flg;
  } vec_t;

  localparam int NVec = 17;
  vec_t tbl[NVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pack_a();
    return 32'({bus_a.Qh, bus_a.Qv, bus_a.hsync, bus_a.vsync, bus_a.video_on,
                bus_a.p_tick, bus_a.fin_linea, bus_a.fin_cuadro});
  endfunction

  function automatic logic [31:0] pack_b();
    return 32'({bus_b.Qh, bus_b.Qv, bus_b.hsync, bus_b.vsync, bus_b.video_on,
                bus_b.p_tick, bus_b.fin_linea, bus_b.fin_cuadro});
  endfunction

  localparam logic [31:0] ResetPack = 32'({10'd0, 10'd0, 6'b110000});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e;
    int guard;
    int qh_hs_fall, qh_hs_rise, qh_vid_fall, hs_low_ticks;
    logic prev_hs, prev_vid;
    int cyc, ticks, lines, vs_lines, vs_ticks, range_err;

    // Edge e counts rising edges after release; counters advance on every even edge.
    tbl[0]  = '{0,   0,  0, 6'b110000};
    tbl[1]  = '{1,   0,  0, 6'b110100};
    tbl[2]  = '{2,   1,  0, 6'b111000};
    tbl[3]  = '{15,  7,  0, 6'b111100};
    tbl[4]  = '{16,  8,  0, 6'b110000};
    tbl[5]  = '{20,  10, 0, 6'b010000};
    tbl[6]  = '{22,  11, 0, 6'b010000};
    tbl[7]  = '{24,  12, 0, 6'b110000};
    tbl[8]  = '{27,  13, 0, 6'b110110};
    tbl[9]  = '{28,  0,  1, 6'b111000};
    tbl[10] = '{98,  7,  3, 6'b111000};
    tbl[11] = '{112, 0,  4, 6'b110000};
    tbl[12] = '{140, 0,  5, 6'b100000};
    tbl[13] = '{168, 0,  6, 6'b110000};
    tbl[14] = '{195, 13, 6, 6'b110111};
    tbl[15] = '{196, 0,  0, 6'b111000};
    tbl[16] = '{197, 0,  0, 6'b111100};

    repeat (10) @(negedge clk);
    chk("a_reset_hold", pack_a(), ResetPack);
    chk("b_reset_hold", pack_b(), ResetPack);

    rst_b_n = 1'b1;
    e = 0;
    for (int i = 0; i < NVec; i++) begin
      while (e < tbl[i].edges) begin
        step();
        e++;
      end
      chk($sformatf("b_vec%0d_e%0d", i, tbl[i].edges), pack_b(),
          32'({10'(tbl[i].qh), 10'(tbl[i].qv), tbl[i].flg}));
    end

    // Full shrunken frame: fin_cuadro to fin_cuadro.
    guard = 0;
    while (!bus_b.fin_cuadro && guard < 400) begin
      step();
      guard++;
    end
    chk("b_frame_sync_timeout", 32'(guard < 400), 32'd1);
    cyc = 0; ticks = 0; lines = 0; vs_lines = 0; vs_ticks = 0; range_err = 0;
    do begin
      step();
      cyc++;
      if (cyc == 1) chk("b_frame_wrap_pos", 32'({bus_b.Qh, bus_b.Qv}), 32'd0);
      if (bus_b.Qh >= 14 || bus_b.Qv >= 7) range_err++;
      if (bus_b.p_tick) ticks++;
      if (bus_b.p_tick && !bus_b.vsync) vs_ticks++;
      if (bus_b.fin_linea) lines++;
      if (bus_b.fin_linea && !bus_b.vsync) vs_lines++;
    end while (!bus_b.fin_cuadro && cyc < 400);
    chk("b_frame_cycles", 32'(cyc), 32'd196);
    chk("b_frame_ticks", 32'(ticks), 32'd98);
    chk("b_frame_lines", 32'(lines), 32'd7);
    chk("b_vsync_lines", 32'(vs_lines), 32'd1);
    chk("b_vsync_ticks", 32'(vs_ticks), 32'd14);
    chk("b_range_errors", 32'(range_err), 32'd0);

    // Default timing: release; p_tick in the 4th cycle counting the release cycle, then every 4.
    chk("a_reset_still", pack_a(), ResetPack);
    rst_a_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("a_ptick_e%0d", k), 32'(bus_a.p_tick), 32'((k % 4) == 3));
    end
    chk("a_after_3_ticks", 32'({bus_a.Qh, bus_a.Qv}), 32'({10'd3, 10'd0}));

    qh_hs_fall = -1; qh_hs_rise = -1; qh_vid_fall = -1; hs_low_ticks = 0;
    prev_hs = bus_a.hsync;
    prev_vid = bus_a.video_on;
    guard = 0;
    while (bus_a.Qv == 10'd0 && guard < 4000) begin
      step();
      guard++;
      if (prev_hs && !bus_a.hsync) qh_hs_fall = int'(bus_a.Qh);
      if (!prev_hs && bus_a.hsync) qh_hs_rise = int'(bus_a.Qh);
      if (prev_vid && !bus_a.video_on) qh_vid_fall = int'(bus_a.Qh);
      if (bus_a.p_tick && !bus_a.hsync) hs_low_ticks++;
      prev_hs = bus_a.hsync;
      prev_vid = bus_a.video_on;
    end
    chk("a_line_timeout", 32'(guard < 4000), 32'd1);
    chk("a_hsync_fall_qh", 32'(qh_hs_fall), 32'd656);
    chk("a_hsync_rise_qh", 32'(qh_hs_rise), 32'd752);
    chk("a_hsync_low_ticks", 32'(hs_low_ticks), 32'd96);
    chk("a_video_fall_qh", 32'(qh_vid_fall), 32'd640);
    chk("a_line1_start", 32'({bus_a.Qh, bus_a.Qv, bus_a.video_on}),
        32'({10'd0, 10'd1, 1'b1}));

    // Line wrap at Qv=10.
    guard = 0;
    while (!(bus_a.Qh == 10'd799 && bus_a.Qv == 10'd10) && guard < 40000) begin
      step();
      guard++;
    end
    chk("a_reach_799_10", 32'(guard < 40000), 32'd1);
    chk("a_fl_before_tick", 32'({bus_a.p_tick, bus_a.fin_linea}), 32'd0);
    guard = 0;
    while (!bus_a.p_tick && guard < 8) begin
      step();
      guard++;
    end
    chk("a_wrap_tick_cycle", 32'({bus_a.Qh, bus_a.fin_linea, bus_a.fin_cuadro}),
        32'({10'd799, 1'b1, 1'b0}));
    step();
    chk("a_wrap_result", 32'({bus_a.Qh, bus_a.Qv, bus_a.fin_linea, bus_a.fin_cuadro}),
        32'({10'd0, 10'd11, 1'b0, 1'b0}));

    // Asynchronous reset between edges at Qh=300.
    guard = 0;
    while (bus_a.Qh != 10'd300 && guard < 2000) begin
      step();
      guard++;
    end
    chk("a_reach_300", 32'({bus_a.Qh, bus_a.video_on}), 32'({10'd300, 1'b1}));
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("a_async_reset", pack_a(), ResetPack);
    repeat (3) @(negedge clk);
    chk("a_async_hold", pack_a(), ResetPack);
    rst_a_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 3) chk("a_restart_ptick", 32'(bus_a.p_tick), 32'd1);
      if (k == 2) chk("a_restart_no_early", 32'(bus_a.p_tick), 32'd0);
    end
    chk("a_restart_pos", 32'({bus_a.Qh, bus_a.Qv, bus_a.video_on}),
        32'({10'd1, 10'd0, 1'b1}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
